// File: rtl/elevator_pkg.sv
// Shared types and constants for the SCAN elevator car controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE      = 2'd1,
    DOOR_OPEN = 2'd2,
    STOP      = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int FLOOR_W_DEFAULT = 4;
  typedef logic [FLOOR_W_DEFAULT-1:0] floor_t;

endpackage

// File: rtl/elevator_scan_control_if.sv
// Request, floor-counter and status signals between the car controller and its surroundings.
interface elevator_scan_control_if #(
  parameter int NUM_FLOORS = 16,
  parameter int FLOOR_W    = 4
);
  logic [FLOOR_W-1:0]    current_floor;
  logic [NUM_FLOORS-1:0] car_buttons;
  logic [NUM_FLOORS-1:0] hall_up;
  logic [NUM_FLOORS-1:0] hall_down;
  logic                  door_hold;
  logic                  estop;
  logic                  count_enable;
  logic                  up_down;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;
  logic                  busy;

  modport master (
    output current_floor, car_buttons, hall_up, hall_down, door_hold, estop,
    input  count_enable, up_down, door_open, pending, busy
  );

  modport slave (
    input  current_floor, car_buttons, hall_up, hall_down, door_hold, estop,
    output count_enable, up_down, door_open, pending, busy
  );
endinterface

// File: rtl/elevator_request_bank.sv
// Car-call and hall-call request banks with service clearing and SCAN lookahead.
module elevator_request_bank #(
  parameter int NUM_FLOORS = 16,
  parameter int FLOOR_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  dir_up,
  input  logic                  serving,
  input  logic [NUM_FLOORS-1:0] car_buttons,
  input  logic [NUM_FLOORS-1:0] hall_up,
  input  logic [NUM_FLOORS-1:0] hall_down,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  reqs_above,
  output logic                  reqs_below,
  output logic                  stop_here,
  output logic                  reopen
);
  localparam logic [NUM_FLOORS-1:0] ONE     = NUM_FLOORS'(1);
  localparam logic [NUM_FLOORS-1:0] HU_MASK = ~(ONE << (NUM_FLOORS - 1));
  localparam logic [NUM_FLOORS-1:0] HD_MASK = ~ONE;

  logic [NUM_FLOORS-1:0] car_q, up_q, dn_q;
  logic [NUM_FLOORS-1:0] hu_in, hd_in, floor_bit, above_mask, below_mask;
  logic [NUM_FLOORS-1:0] clr_car, clr_up, clr_dn;
  logic                  ahead, sv_up, sv_dn;

  // Top-floor up calls and ground-floor down calls cannot exist.
  assign hu_in = hall_up & HU_MASK;
  assign hd_in = hall_down & HD_MASK;

  assign floor_bit  = ONE << current_floor;
  assign above_mask = ~((floor_bit << 1) - ONE);
  assign below_mask = floor_bit - ONE;

  assign pending    = car_q | up_q | dn_q;
  assign reqs_above = |(pending & above_mask);
  assign reqs_below = |(pending & below_mask);
  assign ahead      = dir_up ? reqs_above : reqs_below;

  // A hall call is served when it matches travel, or when nothing lies ahead.
  assign sv_up = dir_up | ~ahead;
  assign sv_dn = ~dir_up | ~ahead;

  assign stop_here = |(floor_bit & (car_q | (up_q & {NUM_FLOORS{sv_up}})
                                          | (dn_q & {NUM_FLOORS{sv_dn}})));

  assign clr_car = serving ? floor_bit : '0;
  assign clr_up  = (serving && sv_up) ? floor_bit : '0;
  assign clr_dn  = (serving && sv_dn) ? floor_bit : '0;

  assign reopen = serving && |(floor_bit & (car_buttons | (hu_in & {NUM_FLOORS{sv_up}})
                                                        | (hd_in & {NUM_FLOORS{sv_dn}})));

  always_ff @(posedge clk) begin
    if (reset) begin
      car_q <= '0;
      up_q  <= '0;
      dn_q  <= '0;
    end else begin
      car_q <= (car_q | car_buttons) & ~clr_car;
      up_q  <= (up_q | hu_in) & ~clr_up;
      dn_q  <= (dn_q | hd_in) & ~clr_dn;
    end
  end

endmodule

// File: rtl/elevator_scan_control.sv
// Directional-collective (SCAN) car controller: FSM, move/door timers, floor-counter stepping.
module elevator_scan_control #(
  parameter int NUM_FLOORS  = 16,
  parameter int FLOOR_W     = 4,
  parameter int DOOR_CYCLES = 10,
  parameter int MOVE_CYCLES = 1
) (
  input logic                    clk,
  input logic                    reset,
  elevator_scan_control_if.slave bus
);
  import elevator_pkg::*;

  localparam int                 MW          = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int                 DW          = $clog2(DOOR_CYCLES + 1);
  localparam logic [MW-1:0]      MOVE_LAST   = MW'(MOVE_CYCLES - 1);
  localparam logic [DW-1:0]      DOOR_LOAD   = DW'(DOOR_CYCLES);
  localparam logic [DW-1:0]      DOOR_LAST   = DW'(1);
  localparam logic [FLOOR_W:0]   FLOOR_LIMIT = NUM_FLOORS[FLOOR_W:0];
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

  state_t                state, state_nxt;
  logic                  dir, dir_nxt, dir_eff;
  logic [MW-1:0]         move_cnt, move_cnt_nxt;
  logic [DW-1:0]         door_cnt, door_cnt_nxt;
  logic                  floor_valid, move_last, at_limit, ahead, behind;
  logic                  reqs_above, reqs_below, stop_here, reopen;
  logic [NUM_FLOORS-1:0] pending;

  elevator_request_bank #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_bank (
    .clk          (clk),
    .reset        (reset),
    .current_floor(bus.current_floor),
    .dir_up       (dir_eff),
    .serving      (state == DOOR_OPEN),
    .car_buttons  (bus.car_buttons),
    .hall_up      (bus.hall_up),
    .hall_down    (bus.hall_down),
    .pending      (pending),
    .reqs_above   (reqs_above),
    .reqs_below   (reqs_below),
    .stop_here    (stop_here),
    .reopen       (reopen)
  );

  // The end floors leave only one legal direction.
  always_comb begin
    if (bus.current_floor == '0)            dir_eff = DIR_UP;
    else if (bus.current_floor == TOP_FLOOR) dir_eff = DIR_DOWN;
    else                                     dir_eff = dir;
  end

  assign floor_valid = {1'b0, bus.current_floor} < FLOOR_LIMIT;
  assign ahead       = dir_eff ? reqs_above : reqs_below;
  assign behind      = dir_eff ? reqs_below : reqs_above;
  assign move_last   = (move_cnt == MOVE_LAST);
  assign at_limit    = dir ? (bus.current_floor == TOP_FLOOR) : (bus.current_floor == '0);

  assign bus.count_enable = (state == MOVE) && move_last && !bus.estop && !reset && !at_limit;
  assign bus.up_down      = dir;
  assign bus.door_open    = (state == DOOR_OPEN);
  assign bus.pending      = pending;
  assign bus.busy         = (state != IDLE) || (|pending);

  always_comb begin
    state_nxt    = state;
    dir_nxt      = dir;
    move_cnt_nxt = '0;
    door_cnt_nxt = door_cnt;
    case (state)
      IDLE: begin
        if (floor_valid) begin
          dir_nxt = dir_eff;
          if (stop_here) begin
            state_nxt    = DOOR_OPEN;
            door_cnt_nxt = DOOR_LOAD;
          end else if (ahead) begin
            state_nxt = MOVE;
          end else if (behind) begin
            state_nxt = MOVE;
            dir_nxt   = ~dir_eff;
          end
        end
      end
      MOVE: begin
        if (move_last) state_nxt = IDLE;
        else           move_cnt_nxt = move_cnt + MW'(1);
      end
      DOOR_OPEN: begin
        if (bus.door_hold || reopen) begin
          door_cnt_nxt = DOOR_LOAD;
        end else if (door_cnt == DOOR_LAST) begin
          state_nxt    = IDLE;
          door_cnt_nxt = '0;
        end else begin
          door_cnt_nxt = door_cnt - DW'(1);
        end
      end
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Emergency stop overrides everything and drops any partial step.
    if (bus.estop) begin
      state_nxt    = STOP;
      dir_nxt      = dir;
      move_cnt_nxt = '0;
      door_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      dir      <= DIR_UP;
      move_cnt <= '0;
      door_cnt <= '0;
    end else begin
      state    <= state_nxt;
      dir      <= dir_nxt;
      move_cnt <= move_cnt_nxt;
      door_cnt <= door_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_elevator_scan_control.sv
// Bench for elevator_scan_control with a behavioural floor counter per DUT instance.
module tb_elevator_scan_control;
  import elevator_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  elevator_scan_control_if #(.NUM_FLOORS(16), .FLOOR_W(4)) bus ();
  elevator_scan_control_if #(.NUM_FLOORS(16), .FLOOR_W(4)) bus4 ();

  elevator_scan_control #(.NUM_FLOORS(16), .FLOOR_W(4), .DOOR_CYCLES(10), .MOVE_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  elevator_scan_control #(.NUM_FLOORS(16), .FLOOR_W(4), .DOOR_CYCLES(10), .MOVE_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4));

  // Floor counter models, presettable from the stimulus.
  floor_t floor0, floor4, setv0, setv4;
  logic   set0, set4;
  always @(posedge clk) begin
    if (set0)                  floor0 <= setv0;
    else if (bus.count_enable) floor0 <= bus.up_down ? floor0 + 4'd1 : floor0 - 4'd1;
    if (set4)                   floor4 <= setv4;
    else if (bus4.count_enable) floor4 <= bus4.up_down ? floor4 + 4'd1 : floor4 - 4'd1;
  end
  assign bus.current_floor  = floor0;
  assign bus4.current_floor = floor4;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.car_buttons = '0;  bus.hall_up = '0;  bus.hall_down = '0;
    bus.door_hold = 1'b0;  bus.estop = 1'b0;
    bus4.car_buttons = '0; bus4.hall_up = '0; bus4.hall_down = '0;
    bus4.door_hold = 1'b0; bus4.estop = 1'b0;
  endtask

  task automatic do_reset(input int f0, input int f4);
    @(negedge clk);
    clear_inputs();
    reset = 1'b1; set0 = 1'b1; setv0 = floor_t'(f0); set4 = 1'b1; setv4 = floor_t'(f4);
    @(negedge clk);
    reset = 1'b0; set0 = 1'b0; set4 = 1'b0;
  endtask

  task automatic press(input logic [15:0] c, input logic [15:0] hu, input logic [15:0] hd);
    bus.car_buttons = c; bus.hall_up = hu; bus.hall_down = hd;
    @(negedge clk);
    bus.car_buttons = '0; bus.hall_up = '0; bus.hall_down = '0;
  endtask

  typedef struct packed {
    int          start;
    logic [15:0] car;
    logic [15:0] hu;
    logic [15:0] hd;
    int          ups;
    int          downs;
    int          doors;
    int          final_floor;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  initial begin
    int ups, downs, doors, cyc;
    logic prev_door;

    clear_inputs();
    set0 = 1'b1; setv0 = '0; set4 = 1'b1; setv4 = '0;

    //            start car      hall_up  hall_down ups dn doors final
    vecs[0] = '{0,  16'h0020, 16'h0000, 16'h0000, 5,  0,  1, 5};
    vecs[1] = '{3,  16'h0200, 16'h0000, 16'h0040, 6,  3,  2, 6};
    vecs[2] = '{10, 16'h0004, 16'h0000, 16'h0000, 0,  8,  1, 2};
    vecs[3] = '{0,  16'h0000, 16'h0000, 16'h0001, 0,  0,  0, 0};
    vecs[4] = '{15, 16'h0000, 16'h8000, 16'h0000, 0,  0,  0, 15};
    vecs[5] = '{4,  16'h0000, 16'h0010, 16'h0000, 0,  0,  1, 4};
    vecs[6] = '{5,  16'h0000, 16'h0100, 16'h0004, 3,  6,  2, 2};
    vecs[7] = '{12, 16'h0000, 16'h0008, 16'h0000, 0,  9,  1, 3};
    vecs[8] = '{1,  16'h8001, 16'h0000, 16'h0000, 14, 15, 2, 0};
    vecs[9] = '{2,  16'h0001, 16'h0000, 16'h0000, 0,  2,  1, 0};

    // Reset state
    do_reset(0, 0);
    check("rst_count_enable", {31'd0, bus.count_enable}, 32'd0);
    check("rst_up_down",      {31'd0, bus.up_down},      32'd1);
    check("rst_door_open",    {31'd0, bus.door_open},    32'd0);
    check("rst_pending",      {16'd0, bus.pending},      32'd0);
    check("rst_busy",         {31'd0, bus.busy},         32'd0);

    // Table: full service runs counted pulse by pulse
    for (int r = 0; r < NV; r++) begin
      do_reset(vecs[r].start, 0);
      press(vecs[r].car, vecs[r].hu, vecs[r].hd);
      ups = 0; downs = 0; doors = 0; cyc = 0; prev_door = 1'b0;
      while (bus.busy && cyc < 600) begin
        if (bus.count_enable) begin
          if (bus.up_down) ups++;
          else             downs++;
        end
        if (bus.door_open && !prev_door) doors++;
        prev_door = bus.door_open;
        cyc++;
        @(negedge clk);
      end
      check($sformatf("vec%0d_timeout", r), {31'd0, cyc < 600}, 32'd1);
      check($sformatf("vec%0d_ups", r),     ups,               vecs[r].ups);
      check($sformatf("vec%0d_downs", r),   downs,             vecs[r].downs);
      check($sformatf("vec%0d_doors", r),   doors,             vecs[r].doors);
      check($sformatf("vec%0d_floor", r),   {28'd0, floor0},   vecs[r].final_floor);
      check($sformatf("vec%0d_pending", r), {16'd0, bus.pending}, 32'd0);
    end

    // Floor 0 to 5: pulse/IDLE alternation, then exactly 10 door cycles
    do_reset(0, 0);
    press(16'h0020, 16'h0000, 16'h0000);
    for (int i = 0; i < 22; i++) begin
      check($sformatf("t1_ce_c%0d", i),   {31'd0, bus.count_enable}, {31'd0, (i % 2 == 1) && (i <= 9)});
      if (bus.count_enable) check($sformatf("t1_dir_c%0d", i), {31'd0, bus.up_down}, 32'd1);
      check($sformatf("t1_door_c%0d", i), {31'd0, bus.door_open},    {31'd0, (i >= 11) && (i <= 20)});
      @(negedge clk);
    end
    check("t1_floor",   {28'd0, floor0},      32'd5);
    check("t1_pending", {16'd0, bus.pending}, 32'd0);

    // Arrival at 7 moving up with both hall calls and a car call ahead
    do_reset(5, 0);
    press(16'h0400, 16'h0080, 16'h0080);
    cyc = 0;
    while (!bus.door_open && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    check("t3_door_timeout", {31'd0, cyc < 50}, 32'd1);
    check("t3_floor", {28'd0, floor0}, 32'd7);
    @(negedge clk);
    check("t3_pending", {16'd0, bus.pending}, 32'h0480);

    // Door hold for 20 cycles from dwell cycle 3
    do_reset(0, 0);
    press(16'h0001, 16'h0000, 16'h0000);
    for (int i = 0; i < 34; i++) begin
      check($sformatf("t4_door_c%0d", i), {31'd0, bus.door_open}, {31'd0, (i >= 1) && (i <= 32)});
      if (i == 3)  bus.door_hold = 1'b1;
      if (i == 23) bus.door_hold = 1'b0;
      @(negedge clk);
    end

    // MOVE_CYCLES=4: estop on the final move cycle, then a fresh move
    do_reset(0, 2);
    bus4.car_buttons = 16'h0040;
    @(negedge clk);
    bus4.car_buttons = '0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_ce_pre_c%0d", i), {31'd0, bus4.count_enable}, 32'd0);
      @(negedge clk);
    end
    bus4.estop = 1'b1;
    #1;
    check("t5_ce_suppressed", {31'd0, bus4.count_enable}, 32'd0);
    @(negedge clk);
    check("t5_stop_door", {31'd0, bus4.door_open},    32'd0);
    check("t5_stop_busy", {31'd0, bus4.busy},         32'd1);
    check("t5_stop_ce",   {31'd0, bus4.count_enable}, 32'd0);
    check("t5_stop_floor", {28'd0, floor4},           32'd2);
    bus4.car_buttons = 16'h0002;
    @(negedge clk);
    bus4.car_buttons = '0;
    check("t5_latch_in_stop", {16'd0, bus4.pending}, 32'h0042);
    bus4.estop = 1'b0;
    @(negedge clk);
    check("t5_idle_ce", {31'd0, bus4.count_enable}, 32'd0);
    check("t5_idle_dir", {31'd0, bus4.up_down},     32'd1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_ce_c%0d", i), {31'd0, bus4.count_enable}, {31'd0, i == 3});
      if (i == 3) check("t5_ce_dir", {31'd0, bus4.up_down}, 32'd1);
      @(negedge clk);
    end
    check("t5_floor_after", {28'd0, floor4}, 32'd3);

    // Reset in the middle of a door dwell
    do_reset(4, 0);
    press(16'h0210, 16'h0000, 16'h0000);
    @(negedge clk);
    check("t6_door_before", {31'd0, bus.door_open}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_door",    {31'd0, bus.door_open},    32'd0);
    check("t6_rst_pending", {16'd0, bus.pending},      32'd0);
    check("t6_rst_busy",    {31'd0, bus.busy},         32'd0);
    check("t6_rst_ce",      {31'd0, bus.count_enable}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_scan_control.md
Name: elevator_scan_control

Overview:
Second-generation car controller for the elevator simulator, parametrised in floor count, door dwell and per-floor travel time.
- Keeps separate car-call, hall-up and hall-down request banks.
- Runs directional-collective (SCAN) service: hall calls are answered only in the matching travel direction.
- Adds door-hold/re-open and an emergency stop.
- Drives the existing floor counter through count_enable/up_down and receives current_floor back from it.

Parameters:
- NUM_FLOORS, 16: number of floors, minimum 2.
- FLOOR_W, 4: width of the floor index, equal to clog2(NUM_FLOORS).
- DOOR_CYCLES, 10: door dwell in cycles, minimum 2.
- MOVE_CYCLES, 1: cycles spent in MOVE per floor step, minimum 1.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- current_floor, input, FLOOR_W: floor index from the floor counter.
- car_buttons, input, NUM_FLOORS: in-car floor buttons, one-cycle or level.
- hall_up, input, NUM_FLOORS: hall up-call buttons.
- hall_down, input, NUM_FLOORS: hall down-call buttons.
- door_hold, input, 1: holds the door open while high.
- estop, input, 1: emergency stop, level-sensitive.
- count_enable, output, 1: one-cycle floor-step pulse to the floor counter.
- up_down, output, 1: step direction; 1 = up.
- door_open, output, 1: high while in DOOR_OPEN.
- pending, output, NUM_FLOORS: OR of the three request banks.
- busy, output, 1: high when state is not IDLE or pending is non-zero.

Behaviour:
Reset (synchronous, active-high):
- state = IDLE, direction = up, all banks = 0, timers = 0.
- Outputs: count_enable 0, up_down 1, door_open 0, pending 0, busy 0.
- Reset mid-move or mid-dwell aborts the operation; no count_enable pulse is issued on the reset cycle.

Request banks:
- Updated every cycle as bank <= (bank | buttons) & ~clear.
- Ignored bits: hall_up[NUM_FLOORS-1] and hall_down[0].
- ahead = any request strictly above current_floor (direction up) or strictly below it (direction down).

States: IDLE, MOVE, DOOR_OPEN, STOP.

IDLE, evaluated in priority order:
1. estop is high -> STOP.
2. current_floor >= NUM_FLOORS -> stay in IDLE; no movement.
3. Stop condition -> DOOR_OPEN. Stop holds when any of these is true at the current floor:
   - a car call;
   - a hall call matching direction;
   - any hall call, with nothing ahead.
4. Requests ahead -> MOVE in the current direction.
5. Requests only behind -> flip direction, then MOVE.
6. Otherwise stay in IDLE.

Direction is forced up at floor 0 and down at floor NUM_FLOORS-1. count_enable must never step below 0 or above NUM_FLOORS-1.

MOVE:
- The move timer counts MOVE_CYCLES cycles.
- count_enable = 1 and up_down = direction only in the last cycle; then -> IDLE.
- The floor counter updates on that same edge, so IDLE always re-evaluates at the new floor.

DOOR_OPEN:
- Entry cycle:
  - clears car[f];
  - clears the hall call matching direction;
  - clears both hall calls at f if nothing is ahead (service direction flips when requests lie behind).
- While in DOOR_OPEN, the door timer is loaded with DOOR_CYCLES on entry and decrements each cycle.
- The door timer reloads when either of these occurs:
  - door_hold is high;
  - a new press arrives at f for a call being served (that press is cleared and never latched).
- Exit to IDLE in the cycle where the timer == 1 and door_hold is low.
- Unheld dwell is exactly DOOR_CYCLES cycles of door_open.

STOP (emergency):
- estop has top priority from any state and forces count_enable = 0 combinationally in the same cycle.
- The next state is STOP; the move timer is cleared and the partial step is lost.
- Requests keep latching during STOP.
- estop low -> IDLE, with direction unchanged.
- door_open is 0 in STOP.

Simultaneous events:
- A clear and a new press in the same cycle at the same floor resolve to clear.
- estop arriving on the final MOVE cycle suppresses the pulse.

Decomposition:
- Package elevator_pkg holds:
  - the state encoding (IDLE 2'd0, MOVE 2'd1, DOOR_OPEN 2'd2, STOP 2'd3);
  - the DIR_UP / DIR_DOWN constants;
  - a floor index typedef sized by FLOOR_W.
- Sub-module elevator_request_bank, parametrised by NUM_FLOORS:
  - holds the three banks and the clear logic;
  - computes reqs_above, reqs_below and the stop condition for current_floor and direction.
- The FSM and both timers remain in the top level.

Test Plan:
Defaults apply unless stated; the bench models the floor counter.
1. Reset, floor 0, car_buttons[5] pulsed for 1 cycle -> exactly 5 count_enable pulses with up_down = 1, each followed by one IDLE cycle; door_open high for 10 cycles at floor 5; pending = 0 afterwards.
2. Car moving up from floor 3 with car call at 9; hall_down[6] pressed -> passes floor 6 without a door cycle, serves 9, reverses, stops at 6.
3. At floor 7, hall_up[7], hall_down[7] and car_buttons[10] are all latched and the car arrives moving up -> door opens; hall_up[7] cleared; hall_down[7] remains in pending.
4. door_hold high for 20 cycles starting in dwell cycle 3 -> door_open stays high throughout; door closes exactly 10 cycles after door_hold falls.
5. MOVE_CYCLES = 4; estop asserted in move cycle 4 -> no count_enable pulse, state STOP; estop released -> IDLE, then a fresh 4-cycle move in the same direction.
6. Boundaries:
   - At floor 15, hall_up[15] pressed -> ignored, pending = 0.
   - At floor 0 with direction down and a request at 0 -> door opens, with no downward pulse.
   - Reset asserted mid-DOOR_OPEN -> door_open = 0 and pending = 0 on the next cycle.
